// File: rtl/serial_load_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_load_sched
//  Brief    : Round-robin load scheduler sharing one parallel-to-serial shifter
//  Revision : 1.0 - initial release
// ============================================================================
module serial_load_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int SLOT_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       load,
    output logic [DATA_W-1:0]          parallel_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_CW  = $clog2(SLOT_CYCLES);

    localparam logic [c_CW-1:0]  c_LAST_CNT = c_CW'(SLOT_CYCLES - 1);
    localparam logic [c_IDW-1:0] c_LAST_REQ = c_IDW'(NUM_REQ - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_SLOT = 1'b1;

    logic [0:0]         r_state;
    logic [c_CW-1:0]    r_slot_cnt;
    logic [c_IDW-1:0]   r_ptr;
    logic               r_load;
    logic [DATA_W-1:0]  r_parallel_in;
    logic [c_IDW-1:0]   r_grant_id;

    logic               w_last;
    logic               w_window;
    logic               w_found;
    logic [c_IDW-1:0]   w_win;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_ready;

    assign w_last   = (r_state == c_S_SLOT) && (r_slot_cnt == c_LAST_CNT);
    assign w_window = (r_state == c_S_IDLE) || w_last;

    // Search upward from the pointer with wrap; first valid requester wins.
    always_comb begin
        int w_idx;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = c_IDW'(w_idx);
            end
        end
    end

    assign w_accept = !rst && en && w_window && w_found;

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_slot_cnt    <= '0;
            r_ptr         <= '0;
            r_load        <= 1'b0;
            r_parallel_in <= '0;
            r_grant_id    <= '0;
        end else begin
            r_load <= w_accept;
            if (w_accept) begin
                // A grant in the final slot cycle chains straight into a new slot.
                r_state       <= c_S_SLOT;
                r_slot_cnt    <= '0;
                r_parallel_in <= req_data[w_win*DATA_W +: DATA_W];
                r_grant_id    <= w_win;
                r_ptr         <= (w_win == c_LAST_REQ) ? '0 : w_win + 1'b1;
            end else if (r_state == c_S_SLOT) begin
                if (w_last) begin
                    r_state    <= c_S_IDLE;
                    r_slot_cnt <= '0;
                end else begin
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                end
            end
        end
    end

    assign req_ready   = w_ready;
    assign load        = r_load;
    assign parallel_in = r_parallel_in;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state == c_S_SLOT);
    assign frame_done  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_serial_load_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_load_sched
//  Brief    : Self-checking bench for serial_load_sched (4 req, 8 bit, 10 cyc)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_load_sched;

    localparam int c_N  = 4;
    localparam int c_DW = 8;
    localparam int c_SC = 10;

    logic            clk;
    logic            rst;
    logic            en;
    logic [3:0]      req_valid;
    logic [31:0]     req_data;
    logic [3:0]      req_ready;
    logic            load;
    logic [7:0]      parallel_in;
    logic [1:0]      grant_id;
    logic            busy;
    logic            frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_load_sched #(
        .NUM_REQ    (c_N),
        .DATA_W     (c_DW),
        .SLOT_CYCLES(c_SC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .load       (load),
        .parallel_in(parallel_in),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a slot is the time window [L, L+SC-1] after the load at cycle L.
    int          m_cyc   = 0;
    int          m_L     = -1000;
    int          m_ptr   = 0;
    int          m_gid   = 0;
    logic [7:0]  m_pin   = 8'h00;
    bit          m_ok    = 1'b0;
    int          m_win;
    logic        m_busy, m_fd, m_acc;
    logic [3:0]  m_ready;

    initial begin
        forever begin
            @(negedge clk);
            m_busy = (m_cyc >= m_L) && (m_cyc <= m_L + c_SC - 1);
            m_fd   = (m_cyc == m_L + c_SC - 1);
            m_win  = -1;
            for (int k = 0; k < c_N; k++) begin
                if (m_win < 0 && req_valid[(m_ptr + k) % c_N]) m_win = (m_ptr + k) % c_N;
            end
            m_acc   = !rst && en && (m_win >= 0) && (!m_busy || m_fd);
            m_ready = 4'b0000;
            if (m_acc) m_ready[m_win] = 1'b1;
            if (m_ok) begin
                check("model_ready", req_ready, m_ready);
                check("model_load", load, m_cyc == m_L);
                check("model_busy", busy, m_busy);
                check("model_frame_done", frame_done, m_fd);
                check("model_parallel_in", parallel_in, m_pin);
                check("model_grant_id", grant_id, m_gid);
            end
            if (rst) begin
                m_ok  = 1'b1;
                m_L   = -1000;
                m_ptr = 0;
                m_gid = 0;
                m_pin = 8'h00;
            end else if (m_acc) begin
                m_L   = m_cyc + 1;
                m_pin = req_data[m_win*8 +: 8];
                m_gid = m_win;
                m_ptr = (m_win + 1) % c_N;
            end
            m_cyc++;
        end
    end

    // Advance to the start of the n-th next cycle (just after its rising edge).
    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int busy_zero;
    logic [7:0] exp_b;
    logic [1:0] exp_g [4];

    initial begin
        rst = 1'b1; en = 1'b1; req_valid = 4'b0000; req_data = 32'h0;
        go(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_load", load, 1'b0);
        check("reset_busy", busy, 1'b0);

        // Single request
        go(1); req_valid = 4'b0001; req_data[7:0] = 8'hA5;
        @(negedge clk); check("t1_ready", req_ready, 4'b0001);
        go(1); req_valid = 4'b0000;
        @(negedge clk);
        check("t1_load", load, 1'b1);
        check("t1_pin", parallel_in, 8'hA5);
        check("t1_gid", grant_id, 2'd0);
        check("t1_busy", busy, 1'b1);
        go(1); @(negedge clk); check("t1_load_low", load, 1'b0);
        go(8); @(negedge clk);
        check("t1_frame_done", frame_done, 1'b1);
        check("t1_busy_last", busy, 1'b1);
        go(1); @(negedge clk);
        check("t1_idle", busy, 1'b0);

        // All four requesters held valid, after a fresh reset
        go(1); rst = 1'b1;
        go(1); rst = 1'b0; req_data = 32'h44332211; req_valid = 4'b1111;
        @(negedge clk); check("t2_ready", req_ready, 4'b0001);
        busy_zero = 0;
        for (int k = 1; k <= 41; k++) begin
            go(1); @(negedge clk);
            if (!busy) busy_zero++;
            if (k % 10 == 1) begin
                exp_b = 8'h11 * 8'((k / 10) % 4 + 1);
                check("t2_load", load, 1'b1);
                check("t2_pin", parallel_in, exp_b);
            end
        end
        check("t2_busy_never_drops", busy_zero, 0);
        go(1); req_valid = 4'b0000;
        go(12);

        // Fairness: grant 1, then 1010 held
        req_valid = 4'b0010;
        @(negedge clk); check("t3_ready", req_ready, 4'b0010);
        go(1); req_valid = 4'b1010;
        exp_g[0] = 2'd3; exp_g[1] = 2'd1; exp_g[2] = 2'd3; exp_g[3] = 2'd1;
        for (int k = 0; k < 4; k++) begin
            go(10); @(negedge clk);
            check("t3_load", load, 1'b1);
            check("t3_gid", grant_id, exp_g[k]);
            check("t3_pin", parallel_in, (exp_g[k] == 2'd3) ? 8'h44 : 8'h22);
        end
        go(1); req_valid = 4'b0000;
        go(12);

        // en drop at slot cycle 3
        req_valid = 4'b0001;
        @(negedge clk); check("t4_ready_start", req_ready, 4'b0001);
        go(1); req_valid = 4'b0000;
        go(3); en = 1'b0; req_valid = 4'b0100;
        for (int k = 4; k <= 14; k++) begin
            @(negedge clk);
            check("t4_ready_gated", req_ready, 4'b0000);
            if (k == 10) check("t4_frame_done", frame_done, 1'b1);
            if (k == 11) check("t4_idle", busy, 1'b0);
            go(1);
        end
        en = 1'b1;
        @(negedge clk); check("t4_ready_en", req_ready, 4'b0100);
        go(1); req_valid = 4'b0000;
        @(negedge clk);
        check("t4_load", load, 1'b1);
        check("t4_gid", grant_id, 2'd2);
        check("t4_pin", parallel_in, 8'h33);

        // Reset at slot_cnt = 4
        go(4); rst = 1'b1;
        go(1); rst = 1'b0; req_valid = 4'b0101;
        @(negedge clk);
        check("t5_load", load, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_pin", parallel_in, 8'h00);
        check("t5_gid", grant_id, 2'd0);
        check("t5_ready", req_ready, 4'b0001);
        go(1); req_valid = 4'b0000;
        @(negedge clk);
        check("t5_load_after", load, 1'b1);
        check("t5_pin_after", parallel_in, 8'h11);
        go(12);

        // Late arrival at slot_cnt = 9 of requester 1's slot
        req_valid = 4'b0010;
        @(negedge clk); check("t6_ready1", req_ready, 4'b0010);
        go(1); req_valid = 4'b0000;
        @(negedge clk); check("t6_load1", load, 1'b1);
        go(9); req_valid = 4'b0100;
        @(negedge clk);
        check("t6_ready2", req_ready, 4'b0100);
        check("t6_no_load", load, 1'b0);
        check("t6_frame_done", frame_done, 1'b1);
        go(1); req_valid = 4'b0000;
        @(negedge clk);
        check("t6_load2", load, 1'b1);
        check("t6_gid", grant_id, 2'd2);
        go(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_load_sched.md
# serial_load_sched

Round-robin load scheduler that shares one 8-bit parallel-to-serial shifter among `NUM_REQ` requesters. Each accepted word becomes a one-cycle `load` pulse, with `parallel_in` driven in the same cycle. The shifter is then protected for a fixed slot of `SLOT_CYCLES` cycles before the next load can issue. The block sits directly in front of the serializer's `load`/`parallel_in` inputs, in place of a single fixed source.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `DATA_W`, default 8: parallel word width.
- `SLOT_CYCLES`, default 10: load-to-load period, counting the load cycle; must be ≥ `DATA_W`+1.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: when 0, no new request is accepted; a slot in progress still completes.
- `req_valid` input `NUM_REQ`: per-requester word available.
- `req_data` input `NUM_REQ`×`DATA_W`: per-requester word; must be held stable while valid until ready.
- `req_ready` output `NUM_REQ`: combinational one-hot accept. A transfer occurs when `req_valid[i]`&`req_ready[i]`.
- `load` output 1: registered one-cycle load strobe to the serializer.
- `parallel_in` output `DATA_W`: registered word; changes only together with a `load` rise.
- `grant_id` output clog2(`NUM_REQ`): index of the last granted requester; held between grants.
- `busy` output 1: high for every cycle of a slot.
- `frame_done` output 1: one-cycle pulse on the last cycle of each slot.

## Operation
- **States**
  - IDLE: `busy`=0.
  - SLOT: `busy`=1; internal `slot_cnt` runs 0..`SLOT_CYCLES`-1.
- **Accept window**
  - The block accepts in state IDLE, or in SLOT when `slot_cnt`=`SLOT_CYCLES`-1.
  - A request is accepted only when `en`=1 and at least one `req_valid` is high.
- **Arbitration**
  - Round-robin. The search starts at `ptr`, where `ptr`=(last granted index+1) mod `NUM_REQ`, and proceeds upward with wrap.
  - The first valid requester found wins.
  - `ptr` resets to 0.
  - `req_ready` is all-zero outside the accept window.
- **On accept of requester w (cycle T)**
  - `req_ready[w]`=1 in cycle T.
  - At the T edge:
    - `load`<=1.
    - `parallel_in`<=`req_data[w]`.
    - `grant_id`<=w.
    - `ptr`<=(w+1) mod `NUM_REQ`.
    - state<=SLOT.
    - `slot_cnt`<=0.
- **In SLOT**
  - `load` is high only in the cycle where `slot_cnt`=0.
  - `slot_cnt` increments every cycle.
  - `frame_done`=1 when `slot_cnt`=`SLOT_CYCLES`-1.
  - If there is no accept in that final cycle, the next state is IDLE. If there is an accept, the next state is SLOT with `slot_cnt`=0, i.e. the loads are exactly `SLOT_CYCLES` apart.
- **`en` handling**
  - `en` only gates acceptance. Dropping `en` mid-slot never shortens or extends the slot.
- **Valid handling**
  - Valid dropped before ready is ignored with no side effects.
  - Valid rising in the final slot cycle is eligible in that same cycle.

## Timing
- **Reset values**, applied at the first edge with `rst`=1, overriding everything including mid-slot:
  - `load`=0, `parallel_in`=0, `grant_id`=0, `busy`=0, `frame_done`=0.
  - `req_ready`=0 while `rst`=1.
  - state=IDLE, `ptr`=0, `slot_cnt`=0.
  - A load pulse cut short by reset is not re-issued.
- **Latency**
  - Accept in cycle T gives `load`=1 in cycle T+1.
  - `busy`=1 in cycles T+1..T+`SLOT_CYCLES`.
  - `frame_done` is asserted in cycle T+`SLOT_CYCLES`.
- **Throughput**
  - One word per `SLOT_CYCLES` cycles under continuous demand.
  - `load` is never high in two cycles closer than `SLOT_CYCLES` apart.
- **Combinational paths**
  - `req_ready` depends combinationally on `req_valid`, `en`, state, `slot_cnt` and `ptr`.
  - No other output is combinational.

## Test plan
Parameters for all scenarios: `NUM_REQ`=4, `DATA_W`=8, `SLOT_CYCLES`=10.

- **Single request.** After reset, set `req_valid`=0001, `req_data[0]`=0xA5 at cycle T.
  - `req_ready`=0001 in T.
  - `load`=1 and `parallel_in`=0xA5 in T+1; `load`=0 in T+2.
  - `grant_id`=0.
  - `busy`=1 in T+1..T+10; `frame_done`=1 only in T+10; IDLE in T+11.
- **All four requesters held valid.** Data 0x11/0x22/0x33/0x44.
  - Loads occur in T+1, T+11, T+21, T+31, T+41.
  - `parallel_in` sequence is 0x11,0x22,0x33,0x44,0x11; `busy` never drops.
- **Fairness.** Grant to requester 1, then `req_valid`=1010 held.
  - The next grants are 3, 1, 3, 1.
- **`en` drop.** Set `en`=0 at slot cycle 3 with `req_valid`=0100.
  - The slot ends at `slot_cnt`=9; `req_ready` stays 0 while `en`=0.
  - `en`=1 in cycle U gives `req_ready[2]`=1 in U and `load` in U+1.
- **Reset mid-slot.** Assert `rst` at `slot_cnt`=4.
  - The next cycle shows `load`=0, `busy`=0, `parallel_in`=0, `grant_id`=0.
  - After release with `req_valid`=0101, requester 0 wins first.
- **Late arrival.** Valid from requester 2 rises exactly at `slot_cnt`=9 of requester 1's slot.
  - `req_ready[2]`=1 in that cycle.
  - The new `load` comes 10 cycles after the previous `load`.
